// File: rtl/spi_mem_bridge_pkg.sv
// Shared constants for the SPI memory bridge: opcodes, device select, byte limit
// and the bridge FSM encoding.
package spi_mem_bridge_pkg;
  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         DEV_SEL_BIT   = 24;
  localparam int         MAX_BYTES     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/spi_mem_bridge_shift_engine.sv
// SPI mode-0 bit engine: two clk cycles per bit, MSB-first TX from a 64-bit frame,
// RX bits captured only during the data phase (bit index 32 and up).
module spi_shift_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        active,
  input  logic [63:0] frame,
  input  logic [5:0]  last_bit,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic [31:0] rx_data,
  output logic        finish
);
  logic [5:0]  cnt;
  logic        phase;
  logic [63:0] tx_sr;
  logic [31:0] rx_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
    end else if (load) begin
      cnt   <= '0;
      phase <= 1'b0;
      tx_sr <= frame;
      rx_sr <= '0;
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
        // cnt[5] set means we are past opcode+address, i.e. in the data phase
        if (cnt[5])
          rx_sr <= {rx_sr[30:0], miso};
      end else begin
        phase <= 1'b0;
        tx_sr <= {tx_sr[62:0], 1'b0};
        if (cnt != last_bit)
          cnt <= cnt + 6'd1;
      end
    end
  end

  assign sclk    = phase;
  assign mosi    = tx_sr[63];
  assign rx_data = rx_sr;
  assign finish  = active & phase & (cnt == last_bit);
endmodule

// File: rtl/spi_mem_bridge.sv
// Bridges the core's level-held memory request onto one SPI transaction to flash
// (cs1) or serial SRAM (cs2); read data is returned left-aligned.
module spi_mem_bridge
  import spi_mem_bridge_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = SPI_CMD_READ,
  parameter logic [7:0] CMD_WRITE = SPI_CMD_WRITE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_request,
  input  logic [2:0]  num_bytes,
  input  logic        is_write,
  input  logic [24:0] target_address,
  input  logic [31:0] write_value,
  output logic [31:0] fetched_value,
  output logic        request_done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs1,
  output logic        cs2,
  input  logic        miso
);
  function automatic logic [2:0] sat_bytes(input logic [2:0] n);
    return (n > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : n;
  endfunction

  function automatic logic [31:0] align_tx(input logic [31:0] v, input logic [2:0] n);
    case (n)
      3'd1:    return {v[7:0], 24'h0};
      3'd2:    return {v[15:0], 16'h0};
      3'd3:    return {v[23:0], 8'h0};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] align_rx(input logic [31:0] v, input logic [2:0] n);
    case (n)
      3'd1:    return {v[7:0], 24'h0};
      3'd2:    return {v[15:0], 16'h0};
      3'd3:    return {v[23:0], 8'h0};
      default: return v;
    endcase
  endfunction

  state_t      state, state_n;
  logic        done_flag;
  logic [2:0]  n_q;
  logic        wr_q;
  logic        load, set_done, clr_done, finish;
  logic [2:0]  n_eff;
  logic        dev_sram, special;
  logic [63:0] frame;
  logic [5:0]  last_bit;
  logic [31:0] rx_data;

  assign n_eff    = sat_bytes(num_bytes);
  assign dev_sram = target_address[DEV_SEL_BIT];
  // Flash is read-only, so a flash write completes without touching the bus
  assign special  = (n_eff == 3'd0) || (is_write && !dev_sram);
  assign frame    = {is_write ? CMD_WRITE : CMD_READ, target_address[23:0],
                     is_write ? align_tx(write_value, n_eff) : 32'h0};
  assign last_bit = 6'd31 + {n_q, 3'b000};

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    set_done = 1'b0;
    clr_done = 1'b0;
    case (state)
      ST_IDLE:
        if (start_request && !done_flag) begin
          if (special) begin
            state_n  = ST_DONE;
            set_done = 1'b1;
          end else begin
            state_n = ST_SHIFT;
            load    = 1'b1;
          end
        end
      ST_SHIFT:
        if (finish) begin
          state_n  = ST_DONE;
          set_done = 1'b1;
        end
      ST_DONE:
        if (!start_request) begin
          state_n  = ST_IDLE;
          clr_done = 1'b1;
        end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      done_flag     <= 1'b0;
      n_q           <= '0;
      wr_q          <= 1'b0;
      cs1           <= 1'b1;
      cs2           <= 1'b1;
      fetched_value <= '0;
    end else begin
      state <= state_n;
      if (set_done)
        done_flag <= 1'b1;
      else if (clr_done)
        done_flag <= 1'b0;
      if (load) begin
        n_q  <= n_eff;
        wr_q <= is_write;
        cs1  <= dev_sram;
        cs2  <= !dev_sram;
        if (!is_write)
          fetched_value <= '0;
      end
      if (finish) begin
        cs1 <= 1'b1;
        cs2 <= 1'b1;
        if (!wr_q)
          fetched_value <= align_rx(rx_data, n_q);
      end
    end
  end

  spi_shift_engine u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .active   (state == ST_SHIFT),
    .frame    (frame),
    .last_bit (last_bit),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .finish   (finish)
  );

  assign request_done = done_flag & start_request;
endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: table of directed requests, randomized requests against
// a frame/latency model, plus back-to-back and mid-transfer reset sequences.
module tb_spi_mem_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_request = 1'b0;
  logic [2:0]  num_bytes = '0;
  logic        is_write = 1'b0;
  logic [24:0] target_address = '0;
  logic [31:0] write_value = '0;
  logic        miso = 1'b0;
  logic [31:0] fetched_value;
  logic        request_done, sclk, mosi, cs1, cs2;

  always #5 clk = ~clk;

  spi_mem_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_request  (start_request),
    .num_bytes      (num_bytes),
    .is_write       (is_write),
    .target_address (target_address),
    .write_value    (write_value),
    .fetched_value  (fetched_value),
    .request_done   (request_done),
    .sclk           (sclk),
    .mosi           (mosi),
    .cs1            (cs1),
    .cs2            (cs2),
    .miso           (miso)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          mon_cnt = 0;
  int          both_low = 0;
  int          stray = 0;
  logic        cs1_seen = 1'b0;
  logic        cs2_seen = 1'b0;
  logic [63:0] cap = '0;
  logic [31:0] slave_word = '0;
  logic [31:0] model_fv = '0;

  // Slave side: record mosi in each sclk-low cycle, present the next miso bit
  always @(negedge clk) begin
    if (!cs1 && !cs2) both_low++;
    if (sclk && cs1 && cs2) stray++;
    if (!cs1) cs1_seen = 1'b1;
    if (!cs2) cs2_seen = 1'b1;
    if ((!cs1 || !cs2) && !sclk) begin
      if (mon_cnt < 64) cap[63-mon_cnt] = mosi;
      miso = (mon_cnt >= 32 && mon_cnt < 64) ? slave_word[63-mon_cnt] : 1'b0;
      mon_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_bytes(input logic [2:0] n);
    return (n > 3'd4) ? 4 : int'(n);
  endfunction

  function automatic bit is_special(input logic [2:0] n, input logic wr, input logic [24:0] addr);
    return (eff_bytes(n) == 0) || (wr && !addr[24]);
  endfunction

  function automatic logic [63:0] model_frame(input logic [2:0] n, input logic wr,
                                              input logic [24:0] addr, input logic [31:0] wv);
    int          ne;
    logic [63:0] hdr, data;
    ne = eff_bytes(n);
    if (is_special(n, wr, addr)) return 64'h0;
    hdr  = {32'h0, (wr ? 8'h02 : 8'h03), addr[23:0]};
    data = wr ? ({32'h0, wv} & ((64'h1 << (8*ne)) - 64'h1)) : 64'h0;
    return (hdr << 32) | (data << (32 - 8*ne));
  endfunction

  task automatic run_req(input logic [2:0] n, input logic wr, input logic [24:0] addr,
                         input logic [31:0] wv, input logic [31:0] slave,
                         input logic [31:0] exp_fv, input int exp_cyc, input logic [1:0] exp_cs);
    int          cyc;
    int          bits;
    logic [63:0] ef;
    bits = is_special(n, wr, addr) ? 0 : 32 + 8*eff_bytes(n);
    ef   = model_frame(n, wr, addr, wv);
    @(negedge clk); #1;
    mon_cnt = 0; both_low = 0; stray = 0; cs1_seen = 1'b0; cs2_seen = 1'b0; cap = '0;
    slave_word = slave;
    num_bytes = n; is_write = wr; target_address = addr; write_value = wv;
    start_request = 1'b1;
    #1;
    check("no_stale_done", 64'(request_done), 64'h0);
    cyc = 0;
    while (!request_done && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 3) begin
        num_bytes = 3'($urandom); is_write = 1'($urandom);
        target_address = 25'($urandom); write_value = $urandom;
      end
    end
    if (!request_done) cyc = -1;
    check("done_cycle", 64'(cyc), 64'(exp_cyc));
    check("fetched_value", 64'(fetched_value), 64'(exp_fv));
    check("mosi_frame", cap, ef);
    check("bit_count", 64'(mon_cnt), 64'(bits));
    check("cs_select", 64'({cs1_seen, cs2_seen}), 64'(exp_cs));
    check("cs_overlap", 64'(both_low), 64'h0);
    check("sclk_stray", 64'(stray), 64'h0);
    check("cs_idle", 64'({cs1, cs2}), 64'h3);
    start_request = 1'b0;
    #1;
    check("done_drop", 64'(request_done), 64'h0);
  endtask

  typedef struct {
    logic [2:0]  n;
    logic        wr;
    logic [24:0] addr;
    logic [31:0] wv;
    logic [31:0] slave;
    logic [31:0] exp_fv;
    int          exp_cyc;
    logic [1:0]  exp_cs;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{3'd4, 1'b0, 25'h0000010, 32'h0,        32'h13050500, 32'h13050500, 129, 2'b10};
    tbl[1] = '{3'd1, 1'b0, 25'h1000004, 32'h0,        32'hAB123456, 32'hAB000000, 81,  2'b01};
    tbl[2] = '{3'd2, 1'b1, 25'h1000008, 32'h1234ABCD, 32'hFFFFFFFF, 32'hAB000000, 97,  2'b01};
    tbl[3] = '{3'd2, 1'b1, 25'h0000100, 32'h55667788, 32'h0,        32'hAB000000, 1,   2'b00};
    tbl[4] = '{3'd0, 1'b0, 25'h1000000, 32'h0,        32'h0,        32'hAB000000, 1,   2'b00};
    tbl[5] = '{3'd7, 1'b0, 25'h1ABCDEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 129, 2'b01};
    tbl[6] = '{3'd3, 1'b0, 25'h0FFFFFF, 32'h0,        32'hCAFEF00D, 32'hCAFEF000, 113, 2'b10};

    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", 64'({cs1, cs2}), 64'h3);
    check("rst_sclk_mosi", 64'({sclk, mosi}), 64'h0);
    check("rst_fetched", 64'(fetched_value), 64'h0);
    check("rst_done", 64'(request_done), 64'h0);
    rst_n = 1'b1;

    // Consecutive entries exercise the one-cycle start drop between requests
    for (int i = 0; i < 7; i++)
      run_req(tbl[i].n, tbl[i].wr, tbl[i].addr, tbl[i].wv, tbl[i].slave,
              tbl[i].exp_fv, tbl[i].exp_cyc, tbl[i].exp_cs);
    model_fv = 32'hCAFEF000;

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  n;
      logic        wr;
      logic [24:0] addr;
      logic [31:0] wv, sl;
      int          ne, cyc;
      logic [1:0]  ecs;
      n = 3'($urandom_range(0, 7)); wr = 1'($urandom_range(0, 1));
      addr = 25'($urandom); wv = $urandom; sl = $urandom;
      ne = eff_bytes(n);
      if (is_special(n, wr, addr)) begin
        cyc = 1; ecs = 2'b00;
      end else begin
        cyc = 2*(32 + 8*ne) + 1;
        ecs = addr[24] ? 2'b01 : 2'b10;
        if (!wr) model_fv = sl & (32'hFFFFFFFF << (32 - 8*ne));
      end
      run_req(n, wr, addr, wv, sl, model_fv, cyc, ecs);
    end

    // Reset in the middle of a flash read, then a clean request
    @(negedge clk); #1;
    mon_cnt = 0; slave_word = 32'h11223344;
    num_bytes = 3'd4; is_write = 1'b0; target_address = 25'h0000040;
    start_request = 1'b1;
    repeat (30) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_cs", 64'({cs1, cs2}), 64'h3);
    check("midrst_sclk", 64'(sclk), 64'h0);
    check("midrst_mosi", 64'(mosi), 64'h0);
    check("midrst_done", 64'(request_done), 64'h0);
    check("midrst_fetched", 64'(fetched_value), 64'h0);
    rst_n = 1'b1;
    start_request = 1'b0;
    run_req(3'd2, 1'b0, 25'h1000020, 32'h0, 32'h5A5AC3C3, 32'h5A5A0000, 97, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
